// File: rtl/reduce_return_if.sv
// Request/return bundle for the reduce_return engine: call arguments in,
// registered result plus busy/done status out.
interface reduce_return_if #(
    parameter int WIDTH = 32,
    parameter int NARGS = 4,
    parameter int SEL_W = (NARGS > 1) ? $clog2(NARGS) : 1
);
    logic                   start;
    logic [1:0]             mode;
    logic [SEL_W-1:0]       sel;
    logic [NARGS*WIDTH-1:0] args;
    logic [WIDTH-1:0]       result;
    logic                   busy;
    logic                   done;

    modport master (output start, mode, sel, args, input result, busy, done);
    modport slave  (input start, mode, sel, args, output result, busy, done);
endinterface

// File: rtl/reduce_return.sv
// Multi-cycle reduction engine: latches NARGS arguments on start, then
// returns one selected argument (PASS) or folds them with SUM/MAX/XOR.
module reduce_return #(
    parameter int WIDTH = 32,
    parameter int NARGS = 4
) (
    input  logic           clk,
    input  logic           reset,
    reduce_return_if.slave bus
);
    localparam int SEL_W = (NARGS > 1) ? $clog2(NARGS) : 1;
    localparam int IDX_W = $clog2(NARGS);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [1:0] MODE_PASS = 2'd0;
    localparam logic [1:0] MODE_SUM  = 2'd1;
    localparam logic [1:0] MODE_MAX  = 2'd2;
    localparam logic [1:0] MODE_XOR  = 2'd3;

    localparam logic [SEL_W:0]   NARGS_EXT = (SEL_W+1)'(NARGS);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NARGS-1);

    logic [0:0]                  state;
    logic [NARGS-1:0][WIDTH-1:0] args_q;
    logic [1:0]                  mode_q;
    logic [SEL_W-1:0]            sel_q;
    logic [IDX_W-1:0]            idx;
    logic [WIDTH-1:0]            acc;
    logic [WIDTH-1:0]            result_q;
    logic                        done_q;

    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] comb_val;
    logic [WIDTH-1:0] pass_val;

    always_comb begin
        cur      = args_q[idx];
        pass_val = '0;
        // Out-of-range selectors return zero rather than aliasing a lane.
        if ({1'b0, sel_q} < NARGS_EXT)
            pass_val = args_q[sel_q];
        case (mode_q)
            MODE_SUM: comb_val = acc + cur;
            MODE_MAX: comb_val = (cur > acc) ? cur : acc;
            MODE_XOR: comb_val = acc ^ cur;
            default:  comb_val = cur;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            args_q   <= '0;
            mode_q   <= MODE_PASS;
            sel_q    <= '0;
            idx      <= '0;
            acc      <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        args_q <= bus.args;
                        mode_q <= bus.mode;
                        sel_q  <= bus.sel;
                        idx    <= '0;
                        acc    <= '0;
                        state  <= RUN;
                    end
                end
                default: begin
                    if (mode_q == MODE_PASS) begin
                        result_q <= pass_val;
                        done_q   <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        acc <= comb_val;
                        idx <= idx + 1'b1;
                        if (idx == LAST_IDX) begin
                            result_q <= comb_val;
                            done_q   <= 1'b1;
                            state    <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.busy   = (state == RUN);
    assign bus.result = result_q;
    assign bus.done   = done_q;
endmodule

// File: tb/tb_reduce_return.sv
// Scoreboard bench for reduce_return: stimulus pushes expected result and
// completion cycle; a negedge monitor pops on every done pulse.
module tb_reduce_return;
    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   nvec = 0;
    int   errs = 0;

    typedef struct {
        logic [31:0] res;
        int          due;
    } exp_t;
    exp_t sbq[$];

    reduce_return_if #(.WIDTH(32), .NARGS(4)) bus ();
    reduce_return #(.WIDTH(32), .NARGS(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Monitor: every done pulse must match the oldest outstanding call.
    always @(negedge clk) begin
        if (!reset && bus.done) begin
            nvec++;
            if (sbq.size() == 0) begin
                errs++;
                $display("FAIL unexpected_done cyc=%0d result=%h", cyc, bus.result);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                if (bus.result !== e.res || cyc != e.due) begin
                    errs++;
                    $display("FAIL done_result got=%h@%0d exp=%h@%0d", bus.result, cyc, e.res, e.due);
                end
            end
        end
    end

    function automatic logic [127:0] pk(input logic [31:0] a0, a1, a2, a3);
        return {a3, a2, a1, a0};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Drive a one-cycle start; returns on the negedge right after the accept edge.
    task automatic issue(input logic [127:0] a, input logic [1:0] m, input logic [1:0] s,
                         input logic [31:0] ex, input int lat, input bit push);
        @(negedge clk);
        bus.start = 1'b1;
        bus.args  = a;
        bus.mode  = m;
        bus.sel   = s;
        if (push) sbq.push_back('{ex, cyc + 1 + lat});
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_after_accept", {31'd0, bus.busy}, 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) begin
            nvec++;
            errs++;
            $display("FAIL idle_timeout busy=%b", bus.busy);
        end
    endtask

    logic [127:0] a_base, a_edge;

    initial begin
        a_base    = pk(32'd10, 32'd20, 32'd30, 32'd40);
        a_edge    = pk(32'd5, 32'hFFFF_FFFF, 32'd7, 32'd3);
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.mode  = 2'd0;
        bus.sel   = 2'd0;
        bus.args  = '0;
        #1;
        chk("reset_result", bus.result, 32'd0);
        chk("reset_busy", {31'd0, bus.busy}, 32'd0);
        chk("reset_done", {31'd0, bus.done}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // PASS: one-cycle latency, busy for exactly one cycle
        issue(a_base, 2'd0, 2'd0, 32'd10, 1, 1'b1);
        @(negedge clk);
        chk("pass_busy_drop", {31'd0, bus.busy}, 32'd0);

        // SUM on base vector, four-cycle latency
        issue(a_base, 2'd1, 2'd0, 32'd100, 4, 1'b1);
        repeat (3) @(negedge clk);
        chk("sum_busy_last", {31'd0, bus.busy}, 32'd1);
        wait_idle();

        issue(a_edge, 2'd2, 2'd0, 32'hFFFF_FFFF, 4, 1'b1); wait_idle();
        issue(a_edge, 2'd3, 2'd0, 32'hFFFF_FFFE, 4, 1'b1); wait_idle();
        issue(a_edge, 2'd1, 2'd0, 32'd14, 4, 1'b1);        wait_idle();
        issue(pk(32'd9, 32'd2, 32'd11, 32'd4), 2'd2, 2'd0, 32'd11, 4, 1'b1); wait_idle();

        // Back-to-back: new call launched in the done cycle
        issue(a_base, 2'd1, 2'd0, 32'd100, 4, 1'b1);
        begin
            int n = 0;
            while (!bus.done && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        bus.start = 1'b1;
        bus.args  = a_base;
        bus.mode  = 2'd0;
        bus.sel   = 2'd2;
        sbq.push_back('{32'd30, cyc + 2});
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();

        // start held high: accepted on every IDLE edge only
        @(negedge clk);
        bus.start = 1'b1;
        bus.mode  = 2'd0;
        bus.sel   = 2'd1;
        bus.args  = a_base;
        sbq.push_back('{32'd20, cyc + 2});
        sbq.push_back('{32'd20, cyc + 4});
        repeat (4) @(negedge clk);
        bus.start = 1'b0;
        wait_idle();

        // Wrap-around SUM, plus a start during busy that must be ignored
        issue(pk(32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0), 2'd1, 2'd0, 32'd1, 4, 1'b1);
        @(negedge clk);
        bus.start = 1'b1;
        bus.mode  = 2'd0;
        bus.sel   = 2'd3;
        bus.args  = a_base;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        chk("ignored_start_hold", bus.result, 32'd1);

        // Inputs changing after the accept edge must not disturb the call
        issue(a_base, 2'd1, 2'd0, 32'd100, 4, 1'b1);
        bus.args = '0;
        bus.mode = 2'd3;
        wait_idle();

        // Reset mid-call: outputs clear immediately, no done afterwards
        issue(a_base, 2'd1, 2'd0, 32'd0, 4, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset     = 1'b1;
        bus.start = 1'b1;
        #1;
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_done", {31'd0, bus.done}, 32'd0);
        chk("abort_result", bus.result, 32'd0);
        repeat (2) @(negedge clk);
        reset     = 1'b0;
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        chk("post_abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("post_abort_result", bus.result, 32'd0);
        issue(a_base, 2'd0, 2'd3, 32'd40, 1, 1'b1);
        wait_idle();

        begin
            int n = 0;
            while (sbq.size() != 0 && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        while (sbq.size() != 0) begin
            exp_t e;
            e = sbq.pop_front();
            nvec++;
            errs++;
            $display("FAIL missing_done exp=%h@%0d", e.res, e.due);
        end
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/reduce_return.md
REDUCE_RETURN -- requirements
Module: reduce_return

Interface
REQ-001 Parameter WIDTH, 32, bit width of each argument and of result.
REQ-002 Parameter NARGS, 4, number of argument channels (>=2).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request pulse; sampled on posedge clk.
REQ-006 mode  input  2  operation: 0 PASS, 1 SUM, 2 MAX (unsigned), 3 XOR.
REQ-007 sel  input  max(1,$clog2(NARGS))  argument index returned in PASS mode.
REQ-008 args  input  NARGS*WIDTH  flattened arguments; arg[i] = args[i*WIDTH +: WIDTH].
REQ-009 result  output  WIDTH  registered return value of the last completed call.
REQ-010 busy  output  1  high while a call is in progress.
REQ-011 done  output  1  one-cycle pulse marking the cycle result first holds a new value.

Function
REQ-012 States IDLE and RUN; busy SHALL equal (state == RUN).
REQ-013 Accept edge: in IDLE, start=1 -> latch args, mode, sel; idx<=0; acc<=0; state<=RUN.
REQ-014 start SHALL be ignored while in RUN; no re-latch, no restart.
REQ-015 PASS: first RUN edge -> result<=arg[sel], done<=1, state<=IDLE; done high 1 cycle after accept edge.
REQ-016 PASS with sel >= NARGS -> result 0, same timing.
REQ-017 SUM/MAX/XOR: each RUN edge combines latched arg[idx] into acc; idx increments.
REQ-018 SUM: acc + arg[idx] modulo 2^WIDTH (wrap, no saturation, no carry-out).
REQ-019 MAX: unsigned max(acc, arg[idx]). XOR: acc ^ arg[idx].
REQ-020 Edge processing idx == NARGS-1 -> result<=final combined value, done<=1, state<=IDLE.
REQ-021 SUM/MAX/XOR latency: done high NARGS cycles after accept edge.
REQ-022 done SHALL be high exactly one cycle per completed call, otherwise 0.
REQ-023 result SHALL change only on a completion edge; holds until next completion.
REQ-024 Changes on args/mode/sel after the accept edge SHALL NOT affect the running call.
REQ-025 start=1 in the cycle done=1 (state IDLE) SHALL be accepted; back-to-back calls allowed.
REQ-026 start held high continuously -> new call accepted on each edge where state is IDLE.

Reset
REQ-027 reset=1 -> immediately, without clock: state IDLE, result 0, busy 0, done 0, idx 0, acc 0.
REQ-028 reset mid-call aborts it; no done pulse; result stays 0 until next completion.
REQ-029 start sampled while reset=1 SHALL be ignored.

Verification (WIDTH=32, NARGS=4, arg0 listed first)
REQ-030 args {10,20,30,40}, mode 0, sel 0, start 1 cycle -> result 10, done 1 cycle after accept edge, busy 1 cycle.
REQ-031 Same args, mode 1 -> result 100, done 4 cycles after accept edge, busy 4 cycles.
REQ-032 args {5,0xFFFFFFFF,7,3}, mode 2 -> 0xFFFFFFFF; mode 3 -> 0xFFFFFFFE; mode 1 -> 14 (wrap).
REQ-033 args {0xFFFFFFFF,2,0,0}, mode 1 -> result 1; then start 2 cycles later during busy with mode 0 -> ignored, single done, result 1.
REQ-034 mode 1 call; assert reset 2 cycles after accept edge -> busy/done/result 0 immediately, no done afterwards; new PASS call sel 3 on {10,20,30,40} -> 40.
REQ-035 Change args to all 0 the edge after accept (mode 1, {10,20,30,40}) -> result still 100.
